// File: rtl/rv32i_regfile_param_if.sv
// Register-file access bundle: two read ports with a shared advance, one write port,
// and the init status flag.
interface rv32i_regfile_param_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd;
    logic            wr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            init_busy;

    modport master (
        output rs1_addr, rs2_addr, rd_en, rd_addr, rd, wr,
        input  rs1, rs2, init_busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_en, rd_addr, rd, wr,
        output rs1, rs2, init_busy
    );
endinterface

// File: rtl/rv32i_regfile_param.sv
// Parameterised RV32I-style register file: two registered read ports with write-first
// bypass and stall hold, one write port, and a one-register-per-cycle clear after reset.
module rv32i_regfile_param #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv32i_regfile_param_if.slave  rf
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] mem [DEPTH];

    logic            wr_ok;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   rs1_sel, rs2_sel;

    logic [AW-1:0]   rs1_cap_p1, rs2_cap_p1;
    logic [XLEN-1:0] rs1_p1, rs2_p1;

    // Address 0 (when hardwired) and the unpopulated tail of the address space read as zero
    // and swallow writes.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (!addr_ok(a))
            return '0;
        if (wr_ok && (wr_addr == a))
            return wr_data;
        return mem[a];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end
    end

    assign wr_addr = rf.rd_addr;
    assign wr_data = rf.rd;
    assign wr_ok   = (state == RUN) && rf.wr && addr_ok(rf.rd_addr);

    // Storage is cleared by the INIT sweep rather than by reset, so it needs no reset branch.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[cnt] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    // Stage p0 -> p1: on stall the held address is re-read, which both keeps the value and
    // picks up a write to that address.
    assign rs1_sel = rf.rd_en ? rf.rs1_addr : rs1_cap_p1;
    assign rs2_sel = rf.rd_en ? rf.rs2_addr : rs2_cap_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_cap_p1 <= '0;
            rs2_cap_p1 <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
        end else if (state == INIT) begin
            rs1_p1 <= '0;
            rs2_p1 <= '0;
        end else begin
            if (rf.rd_en) begin
                rs1_cap_p1 <= rf.rs1_addr;
                rs2_cap_p1 <= rf.rs2_addr;
            end
            rs1_p1 <= read_port(rs1_sel);
            rs2_p1 <= read_port(rs2_sel);
        end
    end

    assign rf.rs1       = rs1_p1;
    assign rf.rs2       = rs2_p1;
    assign rf.init_busy = (state == INIT);
endmodule

// File: tb/tb_rv32i_regfile_param.sv
// Directed bench for rv32i_regfile_param: a DEPTH=32 instance and a DEPTH=24 instance
// sharing clock and reset.
module tb_rv32i_regfile_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   low32, low24;

    always #5 clk = ~clk;

    rv32i_regfile_param_if #(.XLEN(32), .DEPTH(32)) ifa ();
    rv32i_regfile_param_if #(.XLEN(32), .DEPTH(24)) ifb ();

    rv32i_regfile_param #(.XLEN(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (ifa.slave)
    );

    rv32i_regfile_param #(.XLEN(32), .DEPTH(24), .ZERO_REG(1)) u_dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts init_busy cycles from reset release (release happens just after an edge).
    task automatic count_init(output int n32, output int n24);
        n32 = 0;
        n24 = 0;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (!ifb.init_busy && n24 == 0) n24 = k;
            if (!ifa.init_busy) begin
                n32 = k;
                break;
            end
        end
    endtask

    initial begin
        ifa.wr = 1'b1;  ifa.rd_addr = 5'd5;  ifa.rd = 32'h0000DEAD;
        ifa.rd_en = 1'b1; ifa.rs1_addr = 5'd5; ifa.rs2_addr = 5'd5;
        ifb.wr = 1'b0;  ifb.rd_addr = '0;    ifb.rd = '0;
        ifb.rd_en = 1'b0; ifb.rs1_addr = '0; ifb.rs2_addr = '0;

        step();
        step();
        check("reset_rs1", ifa.rs1, 32'h0);
        check("reset_rs2", ifa.rs2, 32'h0);
        check("reset_busy", 32'(ifa.init_busy), 32'h1);

        rst_n = 1'b1;
        count_init(low32, low24);
        check("init_cycles_32", 32'(low32), 32'd32);
        check("init_cycles_24", 32'(low24), 32'd24);

        ifa.wr = 1'b0;
        step();
        check("reg5_after_init", ifa.rs1, 32'h0);

        ifa.wr = 1'b1; ifa.rd_addr = 5'd3; ifa.rd = 32'h12345678; ifa.rd_en = 1'b0;
        step();
        ifa.wr = 1'b0; ifa.rd_en = 1'b1; ifa.rs1_addr = 5'd3;
        step();
        check("read_reg3", ifa.rs1, 32'h12345678);

        ifa.wr = 1'b1; ifa.rd_addr = 5'd7; ifa.rd = 32'hA5A5A5A5; ifa.rs2_addr = 5'd7;
        step();
        check("bypass_rs2", ifa.rs2, 32'hA5A5A5A5);
        check("rs1_independent", ifa.rs1, 32'h12345678);

        ifa.wr = 1'b0; ifa.rs1_addr = 5'd7;
        step();
        check("same_addr_rs1", ifa.rs1, 32'hA5A5A5A5);
        check("same_addr_rs2", ifa.rs2, 32'hA5A5A5A5);

        ifa.wr = 1'b1; ifa.rd_addr = 5'd0; ifa.rd = 32'hFFFFFFFF; ifa.rs1_addr = 5'd0;
        step();
        check("reg0_bypass", ifa.rs1, 32'h0);
        ifa.wr = 1'b0;
        step();
        check("reg0_read", ifa.rs1, 32'h0);

        ifb.wr = 1'b1; ifb.rd_addr = 5'd30; ifb.rd = 32'h0000BEEF;
        ifb.rd_en = 1'b1; ifb.rs1_addr = 5'd30;
        step();
        check("d24_addr30_bypass", ifb.rs1, 32'h0);
        ifb.wr = 1'b0;
        step();
        check("d24_addr30_read", ifb.rs1, 32'h0);
        ifb.wr = 1'b1; ifb.rd_addr = 5'd23; ifb.rd = 32'h00002323;
        step();
        ifb.wr = 1'b0; ifb.rs1_addr = 5'd23;
        step();
        check("d24_last_reg", ifb.rs1, 32'h00002323);

        ifa.wr = 1'b1; ifa.rd_addr = 5'd9; ifa.rd = 32'h11; ifa.rd_en = 1'b0;
        step();
        ifa.wr = 1'b0; ifa.rd_en = 1'b1; ifa.rs1_addr = 5'd9;
        step();
        check("stall_pre", ifa.rs1, 32'h11);
        ifa.rd_en = 1'b0; ifa.rs1_addr = 5'd3;
        ifa.wr = 1'b1; ifa.rd_addr = 5'd9; ifa.rd = 32'h22;
        step();
        check("stall_write_hit", ifa.rs1, 32'h22);
        check("stall_rs2_hold", ifa.rs2, 32'hA5A5A5A5);
        ifa.wr = 1'b0;
        step();
        check("stall_addr_ignored", ifa.rs1, 32'h22);
        ifa.rd_en = 1'b1;
        step();
        check("stall_release", ifa.rs1, 32'h12345678);

        ifa.wr = 1'b1; ifa.rd_addr = 5'd4; ifa.rd = 32'h55;
        step();
        ifa.wr = 1'b0; ifa.rs1_addr = 5'd4; ifa.rs2_addr = 5'd4;
        step();
        check("reg4_pre_reset", ifa.rs1, 32'h55);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rs1", ifa.rs1, 32'h0);
        check("async_rst_rs2", ifa.rs2, 32'h0);
        check("async_rst_busy", 32'(ifa.init_busy), 32'h1);
        step();
        rst_n = 1'b1;
        count_init(low32, low24);
        check("reinit_cycles_32", 32'(low32), 32'd32);
        step();
        check("reg4_after_reinit", ifa.rs1, 32'h0);

        ifa.wr = 1'b1; ifa.rd_addr = 5'd6; ifa.rd = 32'h66; ifa.rs1_addr = 5'd6;
        step();
        ifa.wr = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_init(low32, low24);
        check("abort_init_cycles_32", 32'(low32), 32'd32);
        check("abort_init_cycles_24", 32'(low24), 32'd24);
        step();
        check("reg6_after_abort", ifa.rs1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rv32i_regfile_param.md
RV32I_REGFILE_PARAM -- requirements
Module: rv32i_regfile_param

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter DEPTH, default 32, number of registers (2..64); AW = clog2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rs1_addr  input  AW  read port 1 address.
REQ-007 rs2_addr  input  AW  read port 2 address.
REQ-008 rd_en  input  1  read advance; 0 = stall, hold captured addresses and outputs.
REQ-009 rd_addr  input  AW  write address.
REQ-010 rd  input  XLEN  write data.
REQ-011 wr  input  1  write enable.
REQ-012 rs1  output  XLEN  registered read data, port 1.
REQ-013 rs2  output  XLEN  registered read data, port 2.
REQ-014 init_busy  output  1  high while the clear sequence runs; no accesses accepted.

Function
REQ-015 FSM states INIT and RUN; the block SHALL enter INIT on reset and clear one register per cycle, index counter 0..DEPTH-1.
REQ-016 The INIT->RUN transition SHALL occur on the edge after register DEPTH-1 is cleared; init_busy SHALL be high exactly DEPTH cycles after rst_n rises.
REQ-017 In INIT, wr and rd_en SHALL be ignored and rs1/rs2 SHALL read 0.
REQ-018 In RUN, wr=1 SHALL write rd to regfile[rd_addr] at the rising edge.
REQ-019 Writes to address 0 when ZERO_REG=1, or to address >= DEPTH, SHALL be discarded.
REQ-020 In RUN with rd_en=1, each port SHALL capture its address and present the data at rsN one cycle later (latency 1).
REQ-021 Write-first bypass: same-edge wr to the address being read SHALL make rsN show the new rd, not the old contents.
REQ-022 Stall (rd_en=0): captured addresses held; rsN SHALL hold value, except a wr to a held address SHALL update that rsN on the next cycle.
REQ-023 Reads of address 0 (ZERO_REG=1) or address >= DEPTH SHALL return 0, including under bypass.
REQ-024 rs1 and rs2 SHALL be independent; both ports at the same address SHALL return identical data.
REQ-025 All read/write state SHALL be observable only through rs1/rs2; no combinational path from inputs to outputs.

Reset
REQ-026 rst_n low SHALL asynchronously force rs1=0, rs2=0, init_busy=1, captured addresses=0, counter=0, state=INIT.
REQ-027 rst_n asserted mid-INIT or mid-RUN SHALL abort the operation in progress and restart the full DEPTH-cycle clear after release.
REQ-028 Register contents after INIT SHALL be 0 regardless of pre-reset contents.

Verification
REQ-029 Release rst_n, hold wr=1 rd_addr=5 rd=0xDEAD -> init_busy high 32 cycles; reg5 reads 0 after INIT.
REQ-030 RUN: write reg3=0x12345678, then rd_en=1 rs1_addr=3 -> rs1=0x12345678 one cycle later.
REQ-031 Same edge: wr reg7=0xA5A5A5A5, rs2_addr=7 rd_en=1 -> rs2=0xA5A5A5A5 next cycle (bypass).
REQ-032 Write reg0=0xFFFFFFFF, read rs1_addr=0 -> rs1=0; DEPTH=24 build, read addr 30 -> 0.
REQ-033 Capture rs1_addr=9 (value 0x11), rd_en=0, write reg9=0x22 -> rs1 goes 0x11 to 0x22; rs1_addr changes ignored until rd_en=1.
REQ-034 Write reg4=0x55, pulse rst_n low in RUN -> rs1/rs2 0 immediately, init_busy 1, reg4 reads 0 after new INIT.
